// File: rtl/multdiv_arbiter_if.sv
// rtl/multdiv_arbiter_if.sv - requester, response and multdiv-unit signals of the arbiter
interface multdiv_arbiter_if #(
  parameter int TAG_W = 5
);
  logic             req0_valid;
  logic             req0_op;
  logic [31:0]      req0_a;
  logic [31:0]      req0_b;
  logic [TAG_W-1:0] req0_tag;
  logic             req0_ready;

  logic             req1_valid;
  logic             req1_op;
  logic [31:0]      req1_a;
  logic [31:0]      req1_b;
  logic [TAG_W-1:0] req1_tag;
  logic             req1_ready;

  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [TAG_W-1:0] resp_tag;
  logic [31:0]      resp_result;
  logic             resp_exception;
  logic             resp_timeout;
  logic             busy;

  logic [31:0]      md_operandA;
  logic [31:0]      md_operandB;
  logic             md_ctrl_MULT;
  logic             md_ctrl_DIV;
  logic [31:0]      md_result;
  logic             md_exception;
  logic             md_resultRDY;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req0_tag,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b, req1_tag,
    output req1_ready,
    output resp_valid, resp_id, resp_tag, resp_result, resp_exception, resp_timeout, busy,
    input  resp_ready,
    output md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
    input  md_result, md_exception, md_resultRDY
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req0_tag,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b, req1_tag,
    input  req1_ready,
    input  resp_valid, resp_id, resp_tag, resp_result, resp_exception, resp_timeout, busy,
    output resp_ready,
    input  md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
    output md_result, md_exception, md_resultRDY
  );
endinterface

// File: rtl/multdiv_arbiter.sv
// rtl/multdiv_arbiter.sv - round-robin arbiter sharing one multdiv unit between two requesters
module multdiv_arbiter #(
  parameter int TIMEOUT = 40,
  parameter int TAG_W   = 5
) (
  input logic              clock,
  input logic              reset_n,
  multdiv_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  localparam logic [5:0] WDOG_LAST = 6'(TIMEOUT - 1);

  state_e           state_q;
  logic             last_grant_q;
  logic             id_q;
  logic             busy_q;
  logic             mult_q;
  logic             div_q;
  logic             resp_valid_q;
  logic             resp_exc_q;
  logic             resp_to_q;
  logic [31:0]      opa_q;
  logic [31:0]      opb_q;
  logic [31:0]      result_q;
  logic [TAG_W-1:0] tag_q;
  logic [5:0]       wdog_q;

  logic             grant_d;
  logic             accept_d;
  logic             op_d;
  logic [31:0]      a_d;
  logic [31:0]      b_d;
  logic [TAG_W-1:0] tag_d;

  // Port 1 wins only when it is alone or when port 0 was served last.
  always_comb begin
    grant_d = 1'b0;
    if (bus.req0_valid && bus.req1_valid) grant_d = ~last_grant_q;
    else if (bus.req1_valid)              grant_d = 1'b1;
    accept_d = reset_n && (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);
    op_d  = grant_d ? bus.req1_op  : bus.req0_op;
    a_d   = grant_d ? bus.req1_a   : bus.req0_a;
    b_d   = grant_d ? bus.req1_b   : bus.req0_b;
    tag_d = grant_d ? bus.req1_tag : bus.req0_tag;
  end

  assign bus.req0_ready     = accept_d & ~grant_d;
  assign bus.req1_ready     = accept_d &  grant_d;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_id        = id_q;
  assign bus.resp_tag       = tag_q;
  assign bus.resp_result    = result_q;
  assign bus.resp_exception = resp_exc_q;
  assign bus.resp_timeout   = resp_to_q;
  assign bus.busy           = busy_q;
  assign bus.md_operandA    = opa_q;
  assign bus.md_operandB    = opb_q;
  assign bus.md_ctrl_MULT   = mult_q;
  assign bus.md_ctrl_DIV    = div_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      busy_q       <= 1'b0;
      mult_q       <= 1'b0;
      div_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_exc_q   <= 1'b0;
      resp_to_q    <= 1'b0;
      opa_q        <= '0;
      opb_q        <= '0;
      result_q     <= '0;
      tag_q        <= '0;
      wdog_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            opa_q        <= a_d;
            opb_q        <= b_d;
            tag_q        <= tag_d;
            id_q         <= grant_d;
            last_grant_q <= grant_d;
            div_q        <= op_d;
            mult_q       <= ~op_d;
            busy_q       <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        // resultRDY is still the stale idle-ready here, so it is not looked at.
        ISSUE: begin
          div_q   <= 1'b0;
          mult_q  <= 1'b0;
          wdog_q  <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          wdog_q <= wdog_q + 6'd1;
          if (bus.md_resultRDY) begin
            result_q     <= bus.md_result;
            resp_exc_q   <= bus.md_exception;
            resp_to_q    <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else if (wdog_q == WDOG_LAST) begin
            result_q     <= '0;
            resp_exc_q   <= 1'b1;
            resp_to_q    <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
        end
        // Operands stay put: the unit's divide-by-zero outputs follow them combinationally.
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
